// File: rtl/tds_channel_readout_arbiter.sv
// TDS channel readout arbiter.
// Serves NUM_CH standard-mode decoder FIFOs round-robin, draining up to
// MAX_BURST words per grant. Each word is tagged with its channel id and
// handed downstream over a valid/ready handshake.
// Only one FIFO read is ever outstanding: READ -> LATCH -> SEND per word.
module tds_channel_readout_arbiter #(
  parameter int NUM_CH    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk_readout,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     channel_fifo_empty,
  input  logic [NUM_CH*120-1:0] channel_data,
  output logic [NUM_CH-1:0]     channel_data_read,
  output logic [127:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [31:0]           word_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_READ  = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  state_t               state_q;
  logic [3:0]           grant_q;
  logic [3:0]           last_grant_q;
  logic [7:0]           burst_cnt_q;
  logic [127:0]         out_data_q;
  logic                 out_valid_q;
  logic [31:0]          word_count_q;

  logic [3:0]           arb_grant_d;
  logic                 arb_found_s;
  logic [4:0]           cand_s;
  logic [NUM_CH-1:0]    cand_vec_s;
  logic [NUM_CH-1:0]    empty_shift_s;
  logic                 grant_empty_s;
  logic                 any_ready_s;
  logic                 burst_more_s;
  logic [NUM_CH-1:0]    rd_onehot_s;
  logic [NUM_CH*120-1:0] data_shift_s;
  logic [119:0]         grant_word_s;

  // Round-robin search: first non-empty channel starting after last_grant.
  always_comb begin
    arb_found_s = 1'b0;
    arb_grant_d = last_grant_q;
    cand_s      = 5'd0;
    cand_vec_s  = {NUM_CH{1'b1}};
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_s = {1'b0, last_grant_q} + 5'(k);
      if (cand_s >= 5'(NUM_CH)) begin
        cand_s = cand_s - 5'(NUM_CH);
      end else begin
        cand_s = cand_s;
      end
      cand_vec_s = channel_fifo_empty >> cand_s;
      if (!arb_found_s && !cand_vec_s[0]) begin
        arb_found_s = 1'b1;
        arb_grant_d = cand_s[3:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Per-grant views of the FIFO flags and data; shifts keep indexing width-safe.
  always_comb begin
    empty_shift_s = channel_fifo_empty >> grant_q;
    grant_empty_s = empty_shift_s[0];
    data_shift_s  = channel_data >> (32'(grant_q) * 32'd120);
    grant_word_s  = data_shift_s[119:0];
    any_ready_s   = ~(&channel_fifo_empty);
    burst_more_s  = (({1'b0, burst_cnt_q} + 9'd1) < 9'(MAX_BURST));
    rd_onehot_s   = NUM_CH'(1'b1) << grant_q;
  end

  // Read strobe is gated by the live empty flag so an emptied grant issues no read.
  always_comb begin
    if ((state_q == ST_READ) && !grant_empty_s) begin
      channel_data_read = rd_onehot_s;
    end else begin
      channel_data_read = {NUM_CH{1'b0}};
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign word_count = word_count_q;
  assign busy       = (state_q != ST_IDLE);

  // Readout FSM with registered output word, valid flag and counters.
  always_ff @(posedge clk_readout or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 4'd0;
      last_grant_q <= 4'(NUM_CH - 1);
      burst_cnt_q  <= 8'd0;
      out_data_q   <= 128'd0;
      out_valid_q  <= 1'b0;
      word_count_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && any_ready_s) begin
            state_q <= ST_ARB;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ARB: begin
          if (arb_found_s) begin
            grant_q     <= arb_grant_d;
            burst_cnt_q <= 8'd0;
            state_q     <= ST_READ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (!grant_empty_s) begin
            state_q <= ST_LATCH;
          end else begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end
        end
        ST_LATCH: begin
          // FIFO dout is valid now, one cycle after the read strobe.
          out_data_q  <= {4'b0000, grant_q, grant_word_s};
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            word_count_q <= word_count_q + 32'd1;
            burst_cnt_q  <= burst_cnt_q + 8'd1;
            if (burst_more_s && !grant_empty_s && enable) begin
              state_q <= ST_READ;
            end else begin
              last_grant_q <= grant_q;
              state_q      <= ST_IDLE;
            end
          end else begin
            state_q <= ST_SEND;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tds_channel_readout_arbiter.sv
// Bench for tds_channel_readout_arbiter: FIFO models per channel, a
// transaction-level round-robin/burst reference model, table-driven
// scenarios, hand-written corner sequences and randomized backpressure runs.
module tb_tds_channel_readout_arbiter;
  localparam int NUM_CH = 8;
  localparam int MB     = 16;
  localparam int W      = 120;

  logic                  clk_readout = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [NUM_CH-1:0]     channel_fifo_empty = '1;
  logic [NUM_CH*W-1:0]   channel_data = '0;
  logic [NUM_CH-1:0]     channel_data_read;
  logic [127:0]          out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic [31:0]           word_count;

  tds_channel_readout_arbiter #(.NUM_CH(NUM_CH), .MAX_BURST(MB)) dut (
    .clk_readout        (clk_readout),
    .reset_n            (reset_n),
    .enable             (enable),
    .channel_fifo_empty (channel_fifo_empty),
    .channel_data       (channel_data),
    .channel_data_read  (channel_data_read),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .busy               (busy),
    .word_count         (word_count)
  );

  always #3 clk_readout = ~clk_readout;

  int tests = 0;
  int fails = 0;
  int underflow_err = 0;
  int rd_err = 0;
  int hold_err = 0;
  int rd_count [NUM_CH] = '{default: 0};

  logic [W-1:0] fq [NUM_CH][$];   // FIFO contents seen by the DUT
  logic [W-1:0] mq [NUM_CH][$];   // reference copy of words still expected
  int model_last;
  int model_wc;

  // Standard-mode FIFO model: dout and empty update on the edge after rd_en.
  always @(posedge clk_readout) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (channel_data_read[i]) begin
        if (fq[i].size() == 0) underflow_err <= underflow_err + 1;
        else channel_data[i*W +: W] <= fq[i].pop_front();
        rd_count[i] <= rd_count[i] + 1;
      end
      channel_fifo_empty[i] <= (fq[i].size() == 0);
    end
  end

  // Protocol monitor: output hold under backpressure, one-hot single outstanding read.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [127:0] pd = '0;
  logic         prd = 1'b0;
  always @(negedge clk_readout) begin
    #1;
    if (!reset_n) begin
      pv  <= 1'b0;
      prd <= 1'b0;
    end else begin
      if (pv && !pr && (!out_valid || out_data !== pd)) hold_err <= hold_err + 1;
      if (($countones(channel_data_read) > 1) || (prd && (|channel_data_read)))
        rd_err <= rd_err + 1;
      pv  <= out_valid;
      pr  <= out_ready;
      pd  <= out_data;
      prd <= |channel_data_read;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int ch, input logic [W-1:0] w);
    fq[ch].push_back(w);
    mq[ch].push_back(w);
  endtask

  task automatic load(input int ch, input int n);
    logic [W-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {8'(ch), 16'(k), $urandom(), $urandom(), $urandom()};
      push_word(ch, w);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_readout);
    reset_n   = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    repeat (2) @(negedge clk_readout);
    reset_n    = 1'b1;
    model_last = NUM_CH - 1;
    model_wc   = 0;
    @(negedge clk_readout);
  endtask

  // Predict the whole output stream from queue lengths, then check each handshake.
  task automatic drain(input bit rnd, input int budget, output int grants_obs);
    logic [127:0] eq[$];
    int rem [NUM_CH];
    int last, found, c, n, cycles, grants_exp;
    logic prev_busy;
    grants_exp = 0;
    last = model_last;
    for (int i = 0; i < NUM_CH; i++) rem[i] = mq[i].size();
    forever begin
      found = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (last + k) % NUM_CH;
        if (found < 0 && rem[c] > 0) found = c;
      end
      if (found < 0) break;
      n = (rem[found] > MB) ? MB : rem[found];
      for (int j = 0; j < n; j++) eq.push_back({4'b0000, 4'(found), mq[found].pop_front()});
      rem[found] -= n;
      last = found;
      grants_exp++;
    end
    model_last = last;
    grants_obs = 0;
    cycles = 0;
    prev_busy = 1'b0;
    while (eq.size() > 0 && cycles < budget) begin
      @(negedge clk_readout);
      cycles++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy && !prev_busy) grants_obs++;
      prev_busy = busy;
      if (out_valid && out_ready) begin
        chk("word", out_data, eq.pop_front());
        model_wc++;
      end
    end
    chk("drain_left", eq.size(), 0);
    cycles = 0;
    while (busy && cycles < 20) begin
      @(negedge clk_readout);
      cycles++;
    end
    chk("idle_after", busy, 0);
    chk("word_count", word_count, model_wc);
    chk("grants", grants_obs, grants_exp);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int                words;
    int                exp_total;
    int                exp_grants;
    bit                rnd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [W-1:0] w;
    logic [127:0] d0;
    logic         v [5];
    int g, t, hs, rds, err, r0, n;

    tbl[0] = '{8'b0010_0101, 20, 60, 6, 1'b0};
    tbl[1] = '{8'b0000_1000,  1,  1, 1, 1'b1};
    tbl[2] = '{8'b1000_0000, 16, 16, 1, 1'b1};
    tbl[3] = '{8'b1000_0000, 17, 17, 2, 1'b0};
    tbl[4] = '{8'b1111_1111,  2, 16, 8, 1'b1};
    tbl[5] = '{8'b1000_0001, 33, 66, 6, 1'b1};

    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    model_last = NUM_CH - 1; model_wc = 0;
    repeat (3) @(negedge clk_readout);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_rd", channel_data_read, 0);
    reset_n = 1'b1;
    @(negedge clk_readout);

    // Table-driven scenarios
    for (int i = 0; i < 6; i++) begin
      reset_dut();
      for (int ch = 0; ch < NUM_CH; ch++) if (tbl[i].mask[ch]) load(ch, tbl[i].words);
      repeat (2) @(negedge clk_readout);
      enable = 1'b1;
      drain(tbl[i].rnd, 3000, g);
      chk("tbl_total", word_count, tbl[i].exp_total);
      chk("tbl_grants", g, tbl[i].exp_grants);
    end

    // Single word on ch3 with latency check
    reset_dut();
    w = {$urandom(), $urandom(), $urandom(), 24'h000000, 12'hABC};
    push_word(3, w);
    repeat (2) @(negedge clk_readout);
    r0 = rd_count[3];
    enable = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_readout);
      v[c] = out_valid;
    end
    d0 = out_data;
    chk("lat_cycle3", v[3], 0);
    chk("lat_cycle4", v[4], 1);
    chk("single_data", d0, {4'b0000, 4'd3, w});
    chk("single_chid", d0[123:120], 3);
    repeat (6) @(negedge clk_readout);
    chk("single_wc", word_count, 1);
    chk("single_idle", busy, 0);
    chk("single_reads", rd_count[3] - r0, 1);

    // Backpressure: 10 stalled cycles in SEND
    reset_dut();
    load(1, 3);
    repeat (2) @(negedge clk_readout);
    enable = 1'b1; out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk_readout); t++; end
    chk("bp_valid", out_valid, 1);
    d0 = out_data; err = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_readout);
      if (out_data !== d0 || !out_valid || channel_data_read != 0) err++;
    end
    chk("bp_stable", err, 0);
    chk("bp_wc0", word_count, 0);
    out_ready = 1'b1;
    @(negedge clk_readout);
    out_ready = 1'b0;
    repeat (5) @(negedge clk_readout);
    chk("bp_wc1", word_count, 1);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_word", d0, {4'b0000, 4'd1, mq[1].pop_front()});
    model_wc = 1;
    drain(1'b0, 500, g);

    // Enable drop while LATCH holds the first word
    reset_dut();
    load(2, 5);
    repeat (2) @(negedge clk_readout);
    enable = 1'b1; out_ready = 1'b1;
    t = 0;
    while (!channel_data_read[2] && t < 20) begin @(negedge clk_readout); t++; end
    chk("ed_read_seen", channel_data_read[2], 1);
    @(negedge clk_readout);
    enable = 1'b0;
    hs = 0; rds = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_readout);
      if (|channel_data_read) rds++;
      if (out_valid && out_ready) begin
        chk("ed_word", out_data, {4'b0000, 4'd2, mq[2].pop_front()});
        hs++;
      end
    end
    chk("ed_handshakes", hs, 1);
    chk("ed_no_reads", rds, 0);
    chk("ed_wc", word_count, 1);
    chk("ed_idle", busy, 0);
    model_wc = 1; model_last = 2;
    enable = 1'b1;
    drain(1'b0, 500, g);

    // Reset in SEND during a ch1 burst
    reset_dut();
    load(1, 5);
    load(4, 3);
    repeat (2) @(negedge clk_readout);
    enable = 1'b1;
    n = 0; t = 0;
    do begin
      @(negedge clk_readout);
      t++;
      out_ready = (n < 2);
      if (out_valid && out_ready) begin
        chk("rm_word", out_data, {4'b0000, 4'd1, mq[1].pop_front()});
        n++;
      end
    end while (!(n == 2 && out_valid && !out_ready) && t < 100);
    chk("rm_pre_wc", word_count, 2);
    chk("rm_pre_valid", out_valid, 1);
    void'(mq[1].pop_front());
    reset_n = 1'b0;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_wc", word_count, 0);
    chk("rm_busy", busy, 0);
    chk("rm_rd", channel_data_read, 0);
    repeat (2) @(negedge clk_readout);
    reset_n = 1'b1;
    model_last = NUM_CH - 1; model_wc = 0;
    drain(1'b0, 500, g);

    // All FIFOs empty for 100 cycles
    reset_dut();
    enable = 1'b1;
    err = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_readout);
      if (busy || channel_data_read != 0) err++;
    end
    chk("empty_quiet", err, 0);

    // Randomized fills with random backpressure
    for (int it = 0; it < 6; it++) begin
      reset_dut();
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 1) == 1) load(ch, $urandom_range(1, 40));
      repeat (2) @(negedge clk_readout);
      enable = 1'b1;
      drain(1'b1, 6000, g);
    end

    repeat (3) @(negedge clk_readout);
    chk("hold_violations", hold_err, 0);
    chk("read_violations", rd_err, 0);
    chk("fifo_underflow", underflow_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
